// File: rtl/bin_to_xs3_seq_if.sv
// Handshake bus for the binary-to-decimal converter.
// The master side issues binary words and collects the decimal digits.
interface bin_to_xs3_seq_if #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_bin;
    logic                  in_xs3;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_digits;
    logic                  out_ovf;

    modport master (
        output in_valid, in_bin, in_xs3, out_ready,
        input  in_ready, out_valid, out_digits, out_ovf
    );

    modport slave (
        input  in_valid, in_bin, in_xs3, out_ready,
        output in_ready, out_valid, out_digits, out_ovf
    );
endinterface

// File: rtl/bin_to_xs3_seq.sv
// Iterative binary-to-decimal converter (double dabble), one bit per clock.
// Produces plain BCD or excess-3 digits with a sticky overflow flag.
module bin_to_xs3_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3,
    parameter int unsigned CNT_W  = $clog2(BIN_W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    bin_to_xs3_seq_if.slave    bus
);
    localparam int unsigned ACC_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                xs3_q, xs3_d;
    logic                sticky_q, sticky_d;
    logic [ACC_W-1:0]    digits_q, digits_d;
    logic                ovf_q, ovf_d;
    logic                valid_q, valid_d;

    logic [ACC_W-1:0]    acc_adj;
    logic [ACC_W-1:0]    acc_post;
    logic                top_bit;

    // Pre-shift correction: every digit >= 5 gets +3, all digits in parallel.
    function automatic logic [ACC_W-1:0] add3_ge5(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Excess-3 recoding: +3 per digit, no carry between digits.
    function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            xs3_q    <= 1'b0;
            sticky_q <= 1'b0;
            digits_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            cnt_q    <= cnt_d;
            xs3_q    <= xs3_d;
            sticky_q <= sticky_d;
            digits_q <= digits_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        cnt_d    = cnt_q;
        xs3_d    = xs3_q;
        sticky_d = sticky_q;
        digits_d = digits_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;

        acc_adj  = add3_ge5(acc_q);
        acc_post = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
        top_bit  = acc_adj[ACC_W-1];

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    bin_d    = bus.in_bin;
                    xs3_d    = bus.in_xs3;
                    acc_d    = '0;
                    cnt_d    = '0;
                    sticky_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                acc_d    = acc_post;
                bin_d    = bin_q << 1;
                sticky_d = sticky_q | top_bit;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    digits_d = xs3_q ? add3_all(acc_post) : acc_post;
                    ovf_d    = sticky_q | top_bit;
                    valid_d  = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready drops immediately while reset is asserted, not just after the edge.
    assign bus.in_ready   = (state_q == IDLE) && rst_n;
    assign bus.out_valid  = valid_q;
    assign bus.out_digits = digits_q;
    assign bus.out_ovf    = ovf_q;
endmodule

// File: tb/tb_bin_to_xs3_seq.sv
// Scoreboard bench for bin_to_xs3_seq: a 3-digit instance (main) and a
// 2-digit instance (overflow cases), checked against a decimal reference model.
module tb_bin_to_xs3_seq;
    localparam int unsigned BIN_W = 8;
    localparam int unsigned D3    = 3;
    localparam int unsigned D2    = 2;

    typedef struct {
        logic [31:0] dig;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t q3[$];
    exp_t q2[$];
    int   lat3[$];
    bit   pv3 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_xs3_seq_if #(.BIN_W(BIN_W), .DIGITS(D3)) bus3 ();
    bin_to_xs3_seq_if #(.BIN_W(BIN_W), .DIGITS(D2)) bus2 ();

    bin_to_xs3_seq #(.BIN_W(BIN_W), .DIGITS(D3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave));
    bin_to_xs3_seq #(.BIN_W(BIN_W), .DIGITS(D2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: decimal digits of v (mod 10^d), each +3 in excess-3 mode.
    function automatic exp_t model(input int unsigned v, input bit x, input int unsigned d);
        exp_t        e;
        int unsigned m;
        int unsigned lim;
        e.dig = '0;
        m     = v;
        lim   = 1;
        for (int i = 0; i < int'(d); i++) begin
            e.dig[4*i +: 4] = 4'((m % 10) + (x ? 3 : 0));
            m   = m / 10;
            lim = lim * 10;
        end
        e.ovf = (v >= lim);
        return e;
    endfunction

    // Monitor for the 3-digit instance: latency on rising valid, payload on handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus3.out_valid && !pv3) begin
                if (lat3.size() == 0) chk("d3_unexpected_valid", 32'd1, 32'd0);
                else chk("d3_latency", 32'(cyc - lat3.pop_front()), 32'(BIN_W));
            end
            if (bus3.out_valid && bus3.out_ready) begin
                if (q3.size() == 0) chk("d3_spurious_output", 32'd1, 32'd0);
                else begin
                    e = q3.pop_front();
                    chk("d3_digits", 32'(bus3.out_digits), e.dig);
                    chk("d3_ovf", 32'(bus3.out_ovf), 32'(e.ovf));
                end
            end
        end
        pv3 = rst_n && bus3.out_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) chk("d2_spurious_output", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                chk("d2_digits", 32'(bus2.out_digits), e.dig);
                chk("d2_ovf", 32'(bus2.out_ovf), 32'(e.ovf));
            end
        end
    end

    // Offer one word to the 3-digit instance; returns the cycle count just after acceptance.
    task automatic send3(input int unsigned v, input bit x, input bit push,
                         input exp_t e, output int acc);
        bit ok;
        ok = 1'b0;
        bus3.in_bin   = BIN_W'(v);
        bus3.in_xs3   = x;
        bus3.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus3.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("d3_accept_timeout", 32'd0, 32'd1);
        if (push && ok) q3.push_back(e);
        @(posedge clk);
        #1;
        acc = cyc;
        if (push && ok) lat3.push_back(cyc);
        bus3.in_valid = 1'b0;
    endtask

    task automatic send2(input int unsigned v, input bit x, input exp_t e);
        bit ok;
        ok = 1'b0;
        bus2.in_bin   = BIN_W'(v);
        bus2.in_xs3   = x;
        bus2.in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus2.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk("d2_accept_timeout", 32'd0, 32'd1);
        else q2.push_back(e);
        @(posedge clk);
        #1;
        bus2.in_valid = 1'b0;
    endtask

    function automatic exp_t mk(input logic [31:0] dig, input logic ovf);
        exp_t e;
        e.dig = dig;
        e.ovf = ovf;
        return e;
    endfunction

    initial begin
        int  a1, a2;
        bit  saw;
        bit  done;

        rst_n         = 1'b0;
        bus3.in_valid = 1'b0; bus3.in_bin = '0; bus3.in_xs3 = 1'b0; bus3.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.in_bin = '0; bus2.in_xs3 = 1'b0; bus2.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 32'(bus3.in_ready), 32'd0);
        chk("reset_out_valid", 32'(bus3.out_valid), 32'd0);
        chk("reset_digits", 32'(bus3.out_digits), 32'd0);
        chk("reset_ovf", 32'(bus3.out_ovf), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(bus3.in_ready), 32'd1);

        // Directed conversions with fixed expectations.
        @(posedge clk); #1;
        bus3.out_ready = 1'b1;
        send3(255, 1'b1, 1'b1, mk(32'h588, 1'b0), a1);
        send3(0,   1'b0, 1'b1, mk(32'h000, 1'b0), a1);
        send3(0,   1'b1, 1'b1, mk(32'h333, 1'b0), a1);
        send3(99,  1'b0, 1'b1, mk(32'h099, 1'b0), a1);
        send3(99,  1'b1, 1'b1, mk(32'h3CC, 1'b0), a1);
        send3(10,  1'b0, 1'b1, mk(32'h010, 1'b0), a1);
        send3(11,  1'b1, 1'b1, mk(32'h344, 1'b0), a2);
        chk("throughput", 32'(a2 - a1), 32'(BIN_W + 2));
        for (int i = 0; i < 40 && q3.size() != 0; i++) @(negedge clk);

        // Backpressure: result held while out_ready is low, new input ignored.
        @(posedge clk); #1;
        bus3.out_ready = 1'b0;
        send3(137, 1'b0, 1'b1, mk(32'h137, 1'b0), a1);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus3.out_valid) begin saw = 1'b1; break; end
        end
        chk("bp_valid_timeout", 32'(saw), 32'd1);
        bus3.in_bin   = BIN_W'(55);
        bus3.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid_held", 32'(bus3.out_valid), 32'd1);
            chk("bp_digits_held", 32'(bus3.out_digits), 32'h137);
            chk("bp_in_ready_low", 32'(bus3.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus3.in_valid  = 1'b0;
        bus3.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_cleared", 32'(bus3.out_valid), 32'd0);
        chk("bp_in_ready_back", 32'(bus3.in_ready), 32'd1);

        // Reset during SHIFT discards the conversion.
        @(posedge clk); #1;
        send3(200, 1'b0, 1'b0, mk(32'h200, 1'b0), a1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw |= bus3.out_valid;
        end
        chk("rst_no_valid", 32'(saw), 32'd0);
        chk("rst_digits_zero", 32'(bus3.out_digits), 32'd0);
        chk("rst_in_ready", 32'(bus3.in_ready), 32'd1);
        @(posedge clk); #1;
        send3(42, 1'b0, 1'b1, mk(32'h042, 1'b0), a1);

        // Two-digit instance: overflow boundaries, then a few random values.
        send2(200, 1'b0, mk(32'h00, 1'b1));
        send2(99,  1'b0, mk(32'h99, 1'b0));
        send2(100, 1'b1, mk(32'h33, 1'b1));
        for (int i = 0; i < 30; i++) begin
            int unsigned v;
            bit          x;
            v = $urandom_range(0, 255);
            x = 1'($urandom_range(0, 1));
            send2(v, x, model(v, x, D2));
        end

        // Randomised traffic with random consumer stalls.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    int unsigned v;
                    bit          x;
                    int          a;
                    v = $urandom_range(0, 255);
                    x = 1'($urandom_range(0, 1));
                    send3(v, x, 1'b1, model(v, x, D3), a);
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge clk);
                        #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus3.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus3.out_ready = 1'b1;
            end
        join

        for (int i = 0; i < 300 && (q3.size() != 0 || q2.size() != 0); i++) @(negedge clk);
        chk("d3_drain", 32'(q3.size()), 32'd0);
        chk("d2_drain", 32'(q2.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
